result_writeback: RTL and testbench

- Write-side counterpart of the memory feeder that fills the matrix/vector FIFOs.
- On `start`, snapshots the eight 24-bit MAC results from the matrix-vector multiplier.
- Writes them back to memory through a single Avalon-MM-style write master, one result per transfer, then pulses `done`.
- Sits between the multiplier's `results` bus and the shared memory interconnect.

---
 rtl/result_writeback.sv | 116 +++++++++++
 tb/tb_result_writeback.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/result_writeback.sv
// Result writeback: snapshots the multiplier's MAC results on start and
// streams them to memory through an Avalon-MM style write master, one
// result per transfer in ascending index order, then pulses done.
module result_writeback #(
  parameter int unsigned NUM_RES = 8,
  parameter int unsigned RES_W   = 24,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [RES_W-1:0]  results [NUM_RES],
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic              mem_waitrequest
);

  localparam int unsigned IDX_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ADDR_W-1:0]   base_q;
  logic [RES_W-1:0]    snap_q [NUM_RES];
  logic                busy_q;
  logic                done_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [DATA_W-1:0]   mem_writedata_q;

  logic [IDX_W-1:0]    idx_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;

  // Address and data of the transfer following the one currently presented.
  always_comb begin
    idx_d  = idx_q + IDX_W'(1);
    addr_d = base_q + (ADDR_W'(idx_d) << 2);
    data_d = DATA_W'(snap_q[idx_d]);
  end

  // Control FSM with registered bus outputs; held stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      base_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      for (int i = 0; i < int'(NUM_RES); i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            snap_q          <= results;
            base_q          <= base_addr;
            idx_q           <= '0;
            busy_q          <= 1'b1;
            mem_write_q     <= 1'b1;
            mem_address_q   <= base_addr;
            mem_writedata_q <= DATA_W'(results[0]);
            state_q         <= WRITE;
          end
        end
        WRITE: begin
          if (!mem_waitrequest) begin
            if (idx_q == LAST_IDX) begin
              mem_write_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              idx_q           <= idx_d;
              mem_address_q   <= addr_d;
              mem_writedata_q <= data_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: basic streaming, stalls, snapshot
// isolation, ignored start while busy, mid-transfer reset and address wrap.
module tb_result_writeback;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [23:0] results [8];
  logic        busy;
  logic        done;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest;

  int errors = 0;
  int checks = 0;

  result_writeback dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .base_addr       (base_addr),
    .results         (results),
    .busy            (busy),
    .done            (done),
    .mem_address     (mem_address),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_waitrequest (mem_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land just after the edge for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_results();
    for (int i = 0; i < 8; i++) results[i] = 24'h100000 + 24'(i);
  endtask

  // Launch one transaction and check every cycle until done.
  task automatic run_txn(input logic [31:0] base, input int stall_idx, input int stall_n,
                         input bit clobber, input bit second_start, input int exp_done_cyc);
    int  wr_cnt;
    int  stalled;
    int  wr_cycles;
    bit  finished;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    wr_cnt    = 0;
    stalled   = 0;
    wr_cycles = 0;
    finished  = 1'b0;
    base_addr       = base;
    start           = 1'b1;
    mem_waitrequest = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40 && !finished; c++) begin
      if (clobber && c == 1) begin
        for (int i = 0; i < 8; i++) results[i] = 24'hFFFFFF;
      end
      if (second_start && c == 3) begin
        start     = 1'b1;
        base_addr = 32'h0000_2000;
      end else begin
        start = 1'b0;
      end
      mem_waitrequest = 1'b0;
      if (done) begin
        chk("done_cycle", 32'(c), 32'(exp_done_cyc));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("mem_write_at_done", 32'(mem_write), 32'd0);
        chk("write_count", 32'(wr_cnt), 32'd8);
        chk("write_cycles", 32'(wr_cycles), 32'(8 + stall_n));
        finished = 1'b1;
      end else if (mem_write) begin
        wr_cycles++;
        exp_addr = base + 32'(4 * wr_cnt);
        exp_data = 32'h0010_0000 + 32'(wr_cnt);
        chk("busy_in_write", 32'(busy), 32'd1);
        chk("mem_address", mem_address, exp_addr);
        chk("mem_writedata", mem_writedata, exp_data);
        if (wr_cnt == stall_idx && stalled < stall_n) begin
          mem_waitrequest = 1'b1;
          stalled++;
        end else begin
          wr_cnt++;
        end
      end else begin
        chk("no_gap_in_write", 32'(wr_cnt), 32'd99);
      end
      tick();
    end
    start = 1'b0;
    chk("done_seen", 32'(finished), 32'd1);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(mem_write), 32'd0);
    tick();
    chk("no_requeue", 32'(mem_write), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b1;
    base_addr       = 32'h0000_1000;
    mem_waitrequest = 1'b0;
    load_results();

    // Reset wins over a simultaneous start.
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_address", mem_address, 32'd0);
    chk("rst_writedata", mem_writedata, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_start_ignored", 32'(mem_write), 32'd0);
    chk("rst_start_busy", 32'(busy), 32'd0);

    // Basic back-to-back writes.
    run_txn(32'h0000_1000, -1, 0, 1'b0, 1'b0, 9);

    // Three-cycle stall on index 2.
    run_txn(32'h0000_1000, 2, 3, 1'b0, 1'b0, 12);

    // Inputs clobbered the cycle after capture.
    run_txn(32'h0000_1000, -1, 0, 1'b1, 1'b0, 9);
    load_results();

    // Second start during WRITE is ignored.
    run_txn(32'h0000_1000, -1, 0, 1'b0, 1'b1, 9);

    // Reset after the third accepted write, while stalled.
    base_addr = 32'h0000_1000;
    start     = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_mem_write", 32'(mem_write), 32'd1);
    chk("pre_rst_address", mem_address, 32'h0000_100C);
    rst             = 1'b1;
    mem_waitrequest = 1'b1;
    tick();
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_address", mem_address, 32'd0);
    rst             = 1'b0;
    mem_waitrequest = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_rst_quiet_write", 32'(mem_write), 32'd0);
      chk("post_rst_quiet_done", 32'(done), 32'd0);
    end
    run_txn(32'h0000_1000, -1, 0, 1'b0, 1'b0, 9);

    // Address wraps past the top of the address space.
    run_txn(32'hFFFF_FFF8, -1, 0, 1'b0, 1'b0, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
